cache_mem_responder: RTL

- Memory-side responder for the cache refill/write-back port: services the icache/dcache `mem_*` interface.
- Accepts one word read or write at a time from a single cache master.
- Backs requests with an internal word-addressed RAM.
- Completes each request with a one-cycle `mem_ready` pulse after a programmable latency.
- Sits between the dcache/icache and the SoC memory map; serves as the functional memory model for core-level simulation.

---
 rtl/cache_mem_pkg.sv | 20 ++
 rtl/mem_resp_array.sv | 23 ++
 rtl/cache_mem_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache memory responder slice.
package cache_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam int unsigned WORD_BYTES    = 4;
    localparam int unsigned BYTE_OFS_BITS = $clog2(WORD_BYTES);
    localparam int unsigned LAT_CNT_W     = 8;

    // Any set address bit above the word-index field lands outside the array.
    function automatic logic addr_out_of_range(input logic [31:0] addr,
                                               input int unsigned idx_w);
        return (addr >> (BYTE_OFS_BITS + idx_w)) != '0;
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Single-port word RAM: synchronous write, combinational read of the same address.
module mem_resp_array #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache mem_* port with programmable latency.
// Optional completion counters enabled by CACHE_MEM_RESP_STATS_EN.
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS     = 1024,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        busy,
    output logic        err
`ifdef CACHE_MEM_RESP_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [LAT_CNT_W-1:0] RD_LAT_M1 = LAT_CNT_W'(READ_LATENCY - 1);
    localparam logic [LAT_CNT_W-1:0] WR_LAT_M1 = LAT_CNT_W'(WRITE_LATENCY - 1);

    state_e               state_q;
    logic [LAT_CNT_W-1:0] cnt_q;
    logic                 op_wr_q;
    logic [31:0]          addr_q;
    logic [31:0]          wdata_q;
    logic [31:0]          mem_rdata_q;
    logic                 mem_ready_q;
    logic                 busy_q;
    logic                 err_q;

    logic                 req;
    logic [LAT_CNT_W-1:0] lat_m1;
    logic                 go_resp;
    logic                 c_wr;
    logic [31:0]          c_addr;
    logic [31:0]          c_wdata;
    logic                 c_oor;
    logic [IDX_W-1:0]     c_idx;
    logic                 ram_we;
    logic [31:0]          ram_rdata;

    // The commit happens on the edge entering RESP; with a latency of one that
    // edge is also the accept edge, so the live inputs stand in for the latches.
    always_comb begin
        req     = mem_write | mem_read;
        lat_m1  = mem_write ? WR_LAT_M1 : RD_LAT_M1;
        c_wr    = op_wr_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        go_resp = 1'b0;
        case (state_q)
            IDLE: begin
                c_wr    = mem_write;
                c_addr  = mem_addr;
                c_wdata = mem_wdata;
                go_resp = req && (lat_m1 == '0);
            end
            WAIT:    go_resp = (cnt_q == LAT_CNT_W'(1));
            default: go_resp = 1'b0;
        endcase
        c_oor  = addr_out_of_range(c_addr, IDX_W);
        c_idx  = c_addr[BYTE_OFS_BITS +: IDX_W];
        ram_we = go_resp && c_wr && !c_oor;
    end

    mem_resp_array #(
        .WORDS (MEM_WORDS),
        .AW    (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (c_idx),
        .wdata_i (c_wdata),
        .rdata_o (ram_rdata)
    );

`ifdef CACHE_MEM_RESP_STATS_EN
    logic [15:0] rd_count_q;
    logic [15:0] wr_count_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_rdata_q <= '0;
            mem_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef CACHE_MEM_RESP_STATS_EN
            rd_count_q  <= '0;
            wr_count_q  <= '0;
`endif
        end else begin
            mem_ready_q <= go_resp;
            err_q       <= go_resp && c_oor;
            if (go_resp && !c_wr) begin
                mem_rdata_q <= c_oor ? '0 : ram_rdata;
            end
`ifdef CACHE_MEM_RESP_STATS_EN
            if (go_resp && c_wr && (wr_count_q != '1)) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
            if (go_resp && !c_wr && (rd_count_q != '1)) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        op_wr_q <= mem_write;
                        cnt_q   <= lat_m1;
                        state_q <= go_resp ? RESP : WAIT;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (go_resp) begin
                        state_q <= RESP;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rdata = mem_rdata_q;
    assign mem_ready = mem_ready_q;
    assign busy      = busy_q;
    assign err       = err_q;
`ifdef CACHE_MEM_RESP_STATS_EN
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
`endif

endmodule
